// File: rtl/morse_feature_extractor_pkg.sv
// Shared constants, state encoding and helpers for the Morse feature extractor.
package morse_feature_extractor_pkg;

   localparam int              FEAT_W   = 8;
   localparam int              N_SLOTS  = 4;
   localparam int              IDX_W    = 3;
   localparam logic [FEAT_W-1:0] CNT_MAX = 8'd255;
   // idx saturates at N_SLOTS: "every slot used, further marks only raise overflow"
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_SLOTS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2
   } state_e;

   // Increment that sticks at CNT_MAX instead of wrapping.
   function automatic logic [FEAT_W-1:0] sat_inc(input logic [FEAT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/morse_feature_extractor_sat_counter.sv
// 8-bit saturating run counter. Priority: clear, then load1, then inc; all gated by en.
module sat_counter
   import morse_feature_extractor_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clear,
   input  logic              load1,
   input  logic              inc,
   output logic [FEAT_W-1:0] cnt
);

   logic [FEAT_W-1:0] cnt_q, cnt_d;

   // Next count: only moves on enabled cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (clear)      cnt_d = '0;
         else if (load1) cnt_d = 8'd1;
         else if (inc)   cnt_d = sat_inc(cnt_q);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/morse_feature_extractor.sv
// Run-length encodes the synchronized Morse key into up to four mark lengths per
// character and presents them as x1..x4 with a one-cycle pulse after an
// inter-character gap of CHAR_GAP sample ticks.
// The pulse port is called new_pulse because `new` is a reserved word.
module morse_feature_extractor
   import morse_feature_extractor_pkg::*;
#(
   parameter int CHAR_GAP = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  logic              key,
   output logic [FEAT_W-1:0] x1,
   output logic [FEAT_W-1:0] x2,
   output logic [FEAT_W-1:0] x3,
   output logic [FEAT_W-1:0] x4,
   output logic              new_pulse,
   output logic              overflow
);

   // The space counter starts at 1 on the first space tick, so the gap is
   // complete on the tick that sees cnt == CHAR_GAP-1.
   localparam logic [FEAT_W-1:0] GAP_LAST = FEAT_W'(CHAR_GAP - 1);

   logic sync1_q, sync1_d, key_s_q, key_s_d;

   state_e state_q, state_d;

   logic [FEAT_W-1:0] cnt;
   logic cnt_clear, cnt_load1, cnt_inc;
   logic mark_end, emit, gap_done;

   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [N_SLOTS-1:0][FEAT_W-1:0] slot_q, slot_d;
   logic                           ovf_q, ovf_d;

   logic [N_SLOTS-1:0][FEAT_W-1:0] x_q, x_d;
   logic                           new_q, new_d;
   logic                           ovf_out_q, ovf_out_d;

   // Two-flop synchronizer input chain for the asynchronous key.
   always_comb begin
      sync1_d = key;
      key_s_d = sync1_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         key_s_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         key_s_q <= key_s_d;
      end
   end

   assign gap_done = (cnt == GAP_LAST);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; only sample ticks move it.
   always_comb begin
      state_d = state_q;
      if (sample_en) begin
         case (state_q)
            ST_IDLE:  if (key_s_q) state_d = ST_MARK;
            ST_MARK:  if (!key_s_q) state_d = ST_SPACE;
            ST_SPACE: begin
               if (key_s_q)       state_d = ST_MARK;
               else if (gap_done) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: counter commands plus the mark-end and emit strobes.
   always_comb begin
      cnt_clear = 1'b0;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;
      mark_end  = 1'b0;
      emit      = 1'b0;
      if (sample_en) begin
         case (state_q)
            ST_IDLE: if (key_s_q) cnt_load1 = 1'b1;
            ST_MARK: begin
               if (key_s_q) begin
                  cnt_inc = 1'b1;
               end else begin
                  mark_end  = 1'b1;
                  cnt_load1 = 1'b1;   // first space tick counts as 1
               end
            end
            ST_SPACE: begin
               if (key_s_q) begin
                  cnt_load1 = 1'b1;   // intra-character gap is discarded
               end else if (gap_done) begin
                  emit      = 1'b1;
                  cnt_clear = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: cnt_clear = 1'b1;
         endcase
      end
   end

   sat_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sample_en),
      .clear (cnt_clear),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .cnt   (cnt)
   );

   // Slot collection and output capture; new_d defaults low so the pulse lasts one clock.
   always_comb begin
      idx_d     = idx_q;
      slot_d    = slot_q;
      ovf_d     = ovf_q;
      x_d       = x_q;
      ovf_out_d = ovf_out_q;
      new_d     = 1'b0;
      if (mark_end) begin
         if (idx_q < IDX_FULL) slot_d[idx_q[1:0]] = cnt;
         else                  ovf_d = 1'b1;
         idx_d = (idx_q == IDX_FULL) ? idx_q : idx_q + 3'd1;
      end
      if (emit) begin
         x_d       = slot_q;
         ovf_out_d = ovf_q;
         new_d     = 1'b1;
         slot_d    = '0;
         idx_d     = '0;
         ovf_d     = 1'b0;
      end
   end

   // Character collection and registered output state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         slot_q    <= '0;
         ovf_q     <= 1'b0;
         x_q       <= '0;
         new_q     <= 1'b0;
         ovf_out_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         slot_q    <= slot_d;
         ovf_q     <= ovf_d;
         x_q       <= x_d;
         new_q     <= new_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   assign x1        = x_q[0];
   assign x2        = x_q[1];
   assign x3        = x_q[2];
   assign x4        = x_q[3];
   assign new_pulse = new_q;
   assign overflow  = ovf_out_q;

endmodule

// File: tb/tb_morse_feature_extractor.sv
// Directed, table-driven bench for morse_feature_extractor (CHAR_GAP = 24).
module tb_morse_feature_extractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_en = 1'b0;
   logic       key = 1'b0;
   logic [7:0] x1, x2, x3, x4;
   logic       new_pulse, overflow;

   morse_feature_extractor #(.CHAR_GAP(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .key       (key),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .x4        (x4),
      .new_pulse (new_pulse),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int   clk_count = 0;
   int   emits = 0;
   int   last_new_clk = 0;
   int   pulse_err = 0;
   logic prev_new = 1'b0;

   always @(posedge clk) clk_count++;

   // Count pulses and catch any pulse lasting more than one clock.
   always @(negedge clk) begin
      if (new_pulse) begin
         emits++;
         last_new_clk = clk_count;
         if (prev_new) pulse_err++;
      end
      prev_new = new_pulse;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int period = 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // One sample tick: key held for `period` clocks, sample_en on the last one.
   task automatic tick(input logic k);
      key = k;
      for (int i = 0; i < period; i++) begin
         sample_en = (i == period - 1);
         @(negedge clk);
      end
      sample_en = 1'b0;
   endtask

   typedef struct {
      string             name;
      int                period;
      int                n_runs;
      logic [8:0][15:0]  runs;    // alternating mark/space, starting with mark
      int                tail;    // closing space ticks
      int                emits;
      int                ex1, ex2, ex3, ex4;
      int                eovf;
      bit                lat;
   } vec_t;

   function automatic logic [8:0][15:0] runs9(input int a0 = 0, input int a1 = 0,
      input int a2 = 0, input int a3 = 0, input int a4 = 0, input int a5 = 0,
      input int a6 = 0, input int a7 = 0, input int a8 = 0);
      logic [8:0][15:0] r;
      r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2);
      r[3] = 16'(a3); r[4] = 16'(a4); r[5] = 16'(a5);
      r[6] = 16'(a6); r[7] = 16'(a7); r[8] = 16'(a8);
      return r;
   endfunction

   function automatic vec_t mk(input string nm, input int p, input int nr,
      input logic [8:0][15:0] r, input int tl, input int em,
      input int e1, input int e2, input int e3, input int e4, input int eo,
      input bit lt);
      vec_t v;
      v.name = nm; v.period = p; v.n_runs = nr; v.runs = r; v.tail = tl;
      v.emits = em; v.ex1 = e1; v.ex2 = e2; v.ex3 = e3; v.ex4 = e4;
      v.eovf = eo; v.lat = lt;
      return v;
   endfunction

   localparam int NV = 9;
   vec_t tv[NV];

   int e0;
   int fall_clk;

   initial begin
      tv[0] = mk("idle",   1, 0, runs9(),                          100, 0, 0, 0, 0, 0, 0, 1'b0);
      tv[1] = mk("A",      1, 3, runs9(3, 3, 9),                   30,  1, 3, 9, 0, 0, 0, 1'b0);
      tv[2] = mk("five",   1, 9, runs9(3, 3, 9, 3, 3, 3, 9, 3, 3), 24,  1, 3, 9, 3, 9, 1, 1'b0);
      tv[3] = mk("four",   1, 7, runs9(1, 1, 2, 1, 3, 1, 4),       24,  1, 1, 2, 3, 4, 0, 1'b0);
      tv[4] = mk("gap23",  1, 3, runs9(3, 23, 3),                  24,  1, 3, 3, 0, 0, 0, 1'b0);
      tv[5] = mk("sat300", 1, 1, runs9(300),                       24,  1, 255, 0, 0, 0, 0, 1'b0);
      tv[6] = mk("m254",   1, 1, runs9(254),                       24,  1, 254, 0, 0, 0, 0, 1'b0);
      tv[7] = mk("gated",  4, 1, runs9(5),                         24,  1, 5, 0, 0, 0, 0, 1'b1);
      tv[8] = mk("hold",   1, 0, runs9(),                          30,  0, 5, 0, 0, 0, 0, 1'b0);

      // Reset with key toggling: everything must read zero.
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         key = i[0];
         sample_en = 1'b1;
         @(negedge clk);
      end
      sample_en = 1'b0;
      key = 1'b0;
      chk("rst.x1", x1, 0);
      chk("rst.x4", x4, 0);
      chk("rst.new", new_pulse, 0);
      chk("rst.ovf", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         e0 = emits;
         period = tv[i].period;
         for (int r = 0; r < tv[i].n_runs; r++)
            for (int j = 0; j < int'(tv[i].runs[r]); j++)
               tick(r % 2 == 0);
         fall_clk = clk_count;
         repeat (tv[i].tail) tick(1'b0);
         repeat (5) tick(1'b0);
         chk({tv[i].name, ".emits"}, emits - e0, tv[i].emits);
         chk({tv[i].name, ".x1"}, x1, tv[i].ex1);
         chk({tv[i].name, ".x2"}, x2, tv[i].ex2);
         chk({tv[i].name, ".x3"}, x3, tv[i].ex3);
         chk({tv[i].name, ".x4"}, x4, tv[i].ex4);
         chk({tv[i].name, ".ovf"}, overflow, tv[i].eovf);
         if (tv[i].lat) begin
            // 24 ticks of 4 clocks after the falling edge, allowing synchronizer skew
            n_cmp++;
            if ((last_new_clk - fall_clk) < 93 || (last_new_clk - fall_clk) > 99) begin
               n_bad++;
               $display("FAIL %s.latency: got %0d clocks, expected 96 +/- 3",
                        tv[i].name, last_new_clk - fall_clk);
            end
         end
      end
      period = 1;

      // Reset with key toggling after a nonzero emit clears the outputs at once.
      e0 = emits;
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         key = i[1];
         sample_en = 1'b1;
         @(negedge clk);
      end
      sample_en = 1'b0;
      key = 1'b0;
      chk("rst2.x1", x1, 0);
      chk("rst2.new", new_pulse, 0);
      rst_n = 1'b1;
      repeat (100) tick(1'b0);
      chk("rst2.emits", emits - e0, 0);

      // Reset mid-character, then "E": only the E is emitted.
      e0 = emits;
      repeat (3) tick(1'b1);
      repeat (3) tick(1'b0);
      repeat (9) tick(1'b1);
      repeat (3) tick(1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick(1'b1);
      repeat (24) tick(1'b0);
      repeat (5) tick(1'b0);
      chk("midrst.emits", emits - e0, 1);
      chk("midrst.x1", x1, 3);
      chk("midrst.x2", x2, 0);
      chk("midrst.x3", x3, 0);
      chk("midrst.x4", x4, 0);
      chk("midrst.ovf", overflow, 0);

      chk("pulse_width", pulse_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
